// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
// Holds the FSM state encoding, the default geometry and the cache line record.
package cache_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int INDEX_W   = 3;
  localparam int TAG_W     = ADDR_W - INDEX_W;
  localparam int NUM_LINES = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    ALLOCATE,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cache_ctrl_dm_if.sv
// CPU request port and main-memory port of the cache controller in one bundle.
// slave = controller view, master = CPU/memory side view.
interface cache_ctrl_dm_if #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    output cpu_ack, cpu_rdata, mem_address, mem_data, mem_rden, mem_wren
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    input  cpu_ack, cpu_rdata, mem_address, mem_data, mem_rden, mem_wren
  );

endinterface

// File: rtl/cache_line_array.sv
// Line storage for the direct-mapped cache: one combinational read port, one write port.
// Only valid/dirty are reset; tag and data are don't-care while a line is invalid.
module cache_line_array
  import cache_pkg::*;
(
  input  logic               clock,
  input  logic               i_rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output line_t              rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  line_t              wr_line
);

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_line.tag;
      data_mem[wr_idx] <= wr_line.data;
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= wr_line.valid;
      dirty_reg[wr_idx] <= wr_line.dirty;
    end
  end

  // Read is combinational so LOOKUP sees the line written at the preceding edge.
  assign rd_line = {valid_reg[rd_idx], dirty_reg[rd_idx], tag_mem[rd_idx], data_mem[rd_idx]};

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-back / write-allocate cache controller between CPU and main memory.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl_dm #(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int DATA_W  = cache_pkg::DATA_W,
  parameter int INDEX_W = cache_pkg::INDEX_W
) (
  input  logic           clock,
  input  logic           i_rst_n,
  cache_ctrl_dm_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]    hit_count,
  output logic [15:0]    miss_count
`endif
);

  import cache_pkg::*;

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t              state_reg;
  logic                req_we_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [DATA_W-1:0]   req_wdata_reg;
  logic                first_lookup_reg;

  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  line_t               rd_line;
  line_t               wr_line;
  logic                wr_en;
  logic                hit;

  assign req_idx = req_addr_reg[INDEX_W-1:0];
  assign req_tag = req_addr_reg[ADDR_W-1:INDEX_W];
  assign hit     = rd_line.valid && (rd_line.tag == req_tag);

  cache_line_array u_lines (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .rd_idx  (req_idx),
    .rd_line (rd_line),
    .wr_en   (wr_en),
    .wr_idx  (req_idx),
    .wr_line (wr_line)
  );

  // Write-hit merges into the line; writeback only drops dirty; allocate refills from memory.
  always_comb begin
    wr_en   = 1'b0;
    wr_line = rd_line;
    case (state_reg)
      LOOKUP: begin
        if (hit && req_we_reg) begin
          wr_en         = 1'b1;
          wr_line.dirty = 1'b1;
          wr_line.data  = req_wdata_reg;
        end
      end
      WRITEBACK: begin
        wr_en         = 1'b1;
        wr_line.dirty = 1'b0;
      end
      ALLOCATE: begin
        wr_en         = 1'b1;
        wr_line.valid = 1'b1;
        wr_line.dirty = 1'b0;
        wr_line.tag   = req_tag;
        wr_line.data  = bus.mem_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg        <= IDLE;
      req_we_reg       <= 1'b0;
      req_addr_reg     <= '0;
      req_wdata_reg    <= '0;
      first_lookup_reg <= 1'b0;
      bus.cpu_ack      <= 1'b0;
      bus.cpu_rdata    <= '0;
      bus.mem_rden     <= 1'b0;
      bus.mem_wren     <= 1'b0;
      bus.mem_address  <= '0;
      bus.mem_data     <= '0;
    end else begin
      bus.cpu_ack     <= 1'b0;
      bus.mem_rden    <= 1'b0;
      bus.mem_wren    <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_data    <= '0;
      case (state_reg)
        IDLE: begin
          if (bus.cpu_req) begin
            req_we_reg       <= bus.cpu_we;
            req_addr_reg     <= bus.cpu_addr;
            req_wdata_reg    <= bus.cpu_wdata;
            first_lookup_reg <= 1'b1;
            state_reg        <= LOOKUP;
          end
        end
        LOOKUP: begin
          first_lookup_reg <= 1'b0;
          if (hit) begin
            if (!req_we_reg) begin
              bus.cpu_rdata <= rd_line.data;
            end
            bus.cpu_ack <= 1'b1;
            state_reg   <= DONE;
          end else if (rd_line.valid && rd_line.dirty) begin
            // Memory enables are set one edge early so they line up with the state.
            bus.mem_wren    <= 1'b1;
            bus.mem_address <= {rd_line.tag, req_idx};
            bus.mem_data    <= rd_line.data;
            state_reg       <= WRITEBACK;
          end else begin
            bus.mem_rden    <= 1'b1;
            bus.mem_address <= req_addr_reg;
            state_reg       <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          bus.mem_rden    <= 1'b1;
          bus.mem_address <= req_addr_reg;
          state_reg       <= ALLOCATE;
        end
        ALLOCATE: state_reg <= LOOKUP;
        DONE:     state_reg <= IDLE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Only the first LOOKUP of a request is classified; the post-refill re-lookup is skipped.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_reg == LOOKUP && first_lookup_reg) begin
      if (hit) begin
        hit_count <= sat_inc16(hit_count);
      end else begin
        miss_count <= sat_inc16(miss_count);
      end
    end
  end
`endif

endmodule

// File: doc/cache_ctrl_dm.md
Name: cache_ctrl_dm

Overview:
Direct-mapped, write-back, write-allocate cache controller that sits between the CPU request port and the 32x32 single-port main memory.
- Memory has a 5-bit address and a combinational read (q valid while rden=1); a write commits at the clock edge while wren=1.
- Controller holds 8 one-word lines with valid/dirty/tag bits and serves one CPU request at a time via a req/ack handshake.

Parameters:
ADDR_W, 5, word address width (matches main memory)
DATA_W, 32, data word width
INDEX_W, 3, line index bits; TAG_W = ADDR_W-INDEX_W; lines = 2**INDEX_W

Ports:
clock  in  1  single clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address; index=addr[INDEX_W-1:0], tag=addr[ADDR_W-1:INDEX_W]
cpu_wdata  in  DATA_W  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1 and request was a read
mem_address  out  ADDR_W  memory address
mem_data  out  DATA_W  memory write data
mem_rden  out  1  memory read enable
mem_wren  out  1  memory write enable
mem_q  in  DATA_W  memory read data (combinational)

Behaviour:
- Reset (async):
  - State goes to IDLE; all valid/dirty bits cleared.
  - cpu_ack=0, cpu_rdata=0, mem_rden=0, mem_wren=0, mem_address=0, mem_data=0.
  - Line data and tags need no reset.
- FSM states: IDLE, LOOKUP, WRITEBACK, ALLOCATE, DONE.
- IDLE: if cpu_req=1, latch cpu_we/cpu_addr/cpu_wdata into request registers and go to LOOKUP. CPU inputs are don't-care after the latch edge.
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Hit read: capture line data into cpu_rdata; go to DONE.
  - Hit write: write req_wdata into the line, set dirty; go to DONE.
  - Miss with dirty victim: go to WRITEBACK. Miss otherwise: go to ALLOCATE.
- WRITEBACK (1 cycle): mem_wren=1, mem_address={victim_tag,idx}, mem_data=line data; at the edge clear dirty and go to ALLOCATE.
- ALLOCATE (1 cycle): mem_rden=1, mem_address=req_addr; at the edge load mem_q into the line, set tag=req_tag, valid=1, dirty=0; go to LOOKUP. The re-lookup always hits.
- DONE: cpu_ack=1 for exactly one cycle; go to IDLE. A new request is sampled in IDLE no earlier than the next cycle.
- Memory-side outputs are decoded from the state register only. mem_rden and mem_wren are never both 1. Both are 0 in IDLE, LOOKUP and DONE.
- Latency, counted from the IDLE sampling edge to the ack cycle:
  - hit: 2 cycles
  - clean miss: 4 cycles
  - dirty miss: 5 cycles
- cpu_rdata holds its last value until the next read completes.
- cpu_req deasserted mid-transaction is a protocol violation; the controller still completes and pulses ack.
- Reset during WRITEBACK/ALLOCATE aborts: no ack, cache invalid. The memory write is committed only if the edge occurred before reset.

Optional Feature:
CACHE_STATS_EN:
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each is incremented once per request at the first LOOKUP of that request; the re-lookup after ALLOCATE is not counted.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the state_t enum (IDLE, LOOKUP, WRITEBACK, ALLOCATE, DONE)
  - ADDR_W/DATA_W/INDEX_W defaults and the derived TAG_W/NUM_LINES constants
  - a line_t struct {valid, dirty, tag, data}
- One sub-module, cache_line_array, holds the line storage with one read and one write port, plus the valid/dirty reset.
- The FSM and handshake stay in cache_ctrl_dm.

Test Plan:
Bench memory model has 32 words, each initialised after reset to word i = i.
1. After reset, read 5'd7 -> miss. One cycle with mem_rden=1 and mem_address=7; cpu_ack 4 cycles after sampling; cpu_rdata=32'd7; mem_wren never asserted.
2. Read 5'd7 again -> hit. cpu_ack at 2 cycles, cpu_rdata=7, no memory enables.
3. Write 5'd7 with 32'hDEADBEEF -> hit, ack at 2 cycles, no mem_wren. Then read 7 -> 32'hDEADBEEF.
4. Read 5'd15 (index 7, tag 1) -> dirty eviction. WRITEBACK cycle: mem_wren=1, mem_address=7, mem_data=DEADBEEF. Next cycle: mem_rden=1, mem_address=15. Ack at 5 cycles with rdata=32'd15; memory word 7 now reads DEADBEEF.
5. Write miss 5'd3 with 32'h55 -> ALLOCATE reads 3, merge, line dirty, ack at 4 cycles, no mem_wren. Then read 5'd11 -> writeback of 32'h55 to address 3.
6. Assert i_rst_n=0 during ALLOCATE -> cpu_ack stays 0 and all outputs go to 0 immediately. Next read of 7 misses (4-cycle latency). With CACHE_STATS_EN, hit/miss counters read 0 after reset.
